// File: rtl/pj_commit_monitor.sv
// pj_commit_monitor: observes the ROB debug commit port. It keeps a shadow
// architectural register file built only from retired writes, counts
// retirements and RUN cycles, and decides end of program. A program ends when
// it branches to itself (HALTED) or when no commit arrives for too long
// (TIMEOUT). HALTED and TIMEOUT are terminal; only reset_i leaves them.
//
// Handshake: commit_v_i is a plain valid with no ready. Every cycle in which
// it is high presents exactly one retired instruction, and the monitor
// consumes that instruction on the same rising edge. There is no
// back-pressure. In HALTED or TIMEOUT the commit is dropped without any
// effect.
module pj_commit_monitor #(
    parameter int WORD_SIZE_P   = 16,
    parameter int NUM_ARCH_REG  = 8,
    parameter int HALT_REPEAT_P = 2,
    parameter int TIMEOUT_P     = 1024,
    parameter int CNT_WIDTH_P   = 32
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            commit_v_i,
    input  logic [WORD_SIZE_P-1:0]          commit_pc_i,
    input  logic                            commit_w_v_i,
    input  logic [$clog2(NUM_ARCH_REG)-1:0] commit_reg_addr_i,
    input  logic [WORD_SIZE_P-1:0]          commit_reg_val_i,
    input  logic [$clog2(NUM_ARCH_REG)-1:0] reg_r_addr_i,
    output logic [WORD_SIZE_P-1:0]          reg_r_data_o,
    output logic [CNT_WIDTH_P-1:0]          retired_cnt_o,
    output logic [CNT_WIDTH_P-1:0]          cycle_cnt_o,
    output logic                            halt_o,
    output logic [WORD_SIZE_P-1:0]          halt_pc_o,
    output logic                            timeout_o,
    output logic                            done_o,
    output logic [1:0]                      state_dbg_o
);

    // The repeat counter only needs to reach HALT_REPEAT_P, which is at most 15.
    localparam int RPT_W  = 4;
    localparam int IDLE_W = $clog2(TIMEOUT_P + 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALTED  = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [WORD_SIZE_P-1:0]   regs_q [NUM_ARCH_REG];
    logic [WORD_SIZE_P-1:0]   regs_d [NUM_ARCH_REG];
    logic [CNT_WIDTH_P-1:0]   retired_q, retired_d;
    logic [CNT_WIDTH_P-1:0]   cycle_q, cycle_d;
    logic [WORD_SIZE_P-1:0]   halt_pc_q, halt_pc_d;
    logic [WORD_SIZE_P-1:0]   last_pc_q, last_pc_d;
    logic                     last_v_q, last_v_d;
    logic [RPT_W-1:0]         rpt_q, rpt_d, rpt_new;
    logic [IDLE_W-1:0]        idle_q, idle_d, idle_new;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH_P-1:0] sat_inc(input logic [CNT_WIDTH_P-1:0] v);
        return (&v) ? v : v + CNT_WIDTH_P'(1);
    endfunction

    // Next-state logic: in RUN, a commit updates the counters, the shadow
    // registers and the repeat tracking. A cycle with no commit advances the
    // idle count. In HALTED or TIMEOUT everything holds its value.
    always_comb begin
        state_d   = state_q;
        regs_d    = regs_q;
        retired_d = retired_q;
        cycle_d   = cycle_q;
        halt_pc_d = halt_pc_q;
        last_pc_d = last_pc_q;
        last_v_d  = last_v_q;
        rpt_d     = rpt_q;
        idle_d    = idle_q;
        rpt_new   = '0;
        idle_new  = '0;
        if (state_q == ST_RUN) begin
            cycle_d = sat_inc(cycle_q);
            if (commit_v_i) begin
                retired_d = sat_inc(retired_q);
                if (commit_w_v_i) begin
                    regs_d[commit_reg_addr_i] = commit_reg_val_i;
                end
                if (last_v_q && (commit_pc_i == last_pc_q)) begin
                    rpt_new = (&rpt_q) ? rpt_q : rpt_q + RPT_W'(1);
                end else begin
                    rpt_new = RPT_W'(1);
                end
                rpt_d     = rpt_new;
                last_pc_d = commit_pc_i;
                last_v_d  = 1'b1;
                idle_d    = '0;
                if (rpt_new == RPT_W'(HALT_REPEAT_P)) begin
                    state_d   = ST_HALTED;
                    halt_pc_d = commit_pc_i;
                end
            end else begin
                idle_new = (&idle_q) ? idle_q : idle_q + IDLE_W'(1);
                idle_d   = idle_new;
                if (idle_new == IDLE_W'(TIMEOUT_P)) begin
                    state_d = ST_TIMEOUT;
                end
            end
        end
    end

    // State register. A synchronous reset clears every flop and the whole
    // shadow register file.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_RUN;
            regs_q    <= '{default: '0};
            retired_q <= '0;
            cycle_q   <= '0;
            halt_pc_q <= '0;
            last_pc_q <= '0;
            last_v_q  <= 1'b0;
            rpt_q     <= '0;
            idle_q    <= '0;
        end else begin
            state_q   <= state_d;
            regs_q    <= regs_d;
            retired_q <= retired_d;
            cycle_q   <= cycle_d;
            halt_pc_q <= halt_pc_d;
            last_pc_q <= last_pc_d;
            last_v_q  <= last_v_d;
            rpt_q     <= rpt_d;
            idle_q    <= idle_d;
        end
    end

    // Outputs are decoded from registered state only. The read port has no
    // write bypass, so a register written this cycle still reads its old value.
    assign reg_r_data_o  = regs_q[reg_r_addr_i];
    assign retired_cnt_o = retired_q;
    assign cycle_cnt_o   = cycle_q;
    assign halt_o        = (state_q == ST_HALTED);
    assign timeout_o     = (state_q == ST_TIMEOUT);
    assign done_o        = halt_o | timeout_o;
    assign halt_pc_o     = halt_pc_q;
    assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_pj_commit_monitor.sv
// Bench for pj_commit_monitor. u_dut uses 32-bit counters and TIMEOUT_P=16.
// u_sat uses 4-bit counters and TIMEOUT_P=8, for the timeout and saturation
// sequences. Both instances see the same stimulus.
module tb_pj_commit_monitor;

    logic        clk;
    logic        rst;
    logic        cv;
    logic [15:0] pc;
    logic        wv;
    logic [2:0]  ra;
    logic [15:0] rv;
    logic [2:0]  rd_a;

    logic [15:0] d_rdata, d_hpc;
    logic [31:0] d_ret, d_cyc;
    logic        d_halt, d_to, d_done;
    logic [1:0]  d_st;

    logic [15:0] s_rdata, s_hpc;
    logic [3:0]  s_ret, s_cyc;
    logic        s_halt, s_to, s_done;
    logic [1:0]  s_st;

    int total = 0;
    int bad   = 0;

    pj_commit_monitor #(
        .WORD_SIZE_P(16), .NUM_ARCH_REG(8), .HALT_REPEAT_P(2),
        .TIMEOUT_P(16), .CNT_WIDTH_P(32)
    ) u_dut (
        .clk_i(clk), .reset_i(rst), .commit_v_i(cv), .commit_pc_i(pc),
        .commit_w_v_i(wv), .commit_reg_addr_i(ra), .commit_reg_val_i(rv),
        .reg_r_addr_i(rd_a), .reg_r_data_o(d_rdata), .retired_cnt_o(d_ret),
        .cycle_cnt_o(d_cyc), .halt_o(d_halt), .halt_pc_o(d_hpc),
        .timeout_o(d_to), .done_o(d_done), .state_dbg_o(d_st)
    );

    pj_commit_monitor #(
        .WORD_SIZE_P(16), .NUM_ARCH_REG(8), .HALT_REPEAT_P(2),
        .TIMEOUT_P(8), .CNT_WIDTH_P(4)
    ) u_sat (
        .clk_i(clk), .reset_i(rst), .commit_v_i(cv), .commit_pc_i(pc),
        .commit_w_v_i(wv), .commit_reg_addr_i(ra), .commit_reg_val_i(rv),
        .reg_r_addr_i(rd_a), .reg_r_data_o(s_rdata), .retired_cnt_o(s_ret),
        .cycle_cnt_o(s_cyc), .halt_o(s_halt), .halt_pc_o(s_hpc),
        .timeout_o(s_to), .done_o(s_done), .state_dbg_o(s_st)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        cv;
        logic [15:0] pc;
        logic        wv;
        logic [2:0]  ra;
        logic [15:0] rv;
        logic [2:0]  rd_a;
        logic        chk_rd;
        logic [15:0] exp_rd;
        logic [31:0] exp_ret;
        logic [31:0] exp_cyc;
        logic        exp_halt;
        logic [15:0] exp_hpc;
        logic        exp_to;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic c, input logic [15:0] p,
                                input logic w, input logic [2:0] a, input logic [15:0] v,
                                input logic [2:0] rda, input logic chk, input logic [15:0] erd,
                                input logic [31:0] eret, input logic [31:0] ecyc,
                                input logic eh, input logic [15:0] ehpc, input logic eto);
        vec_t t;
        t.rst = r; t.cv = c; t.pc = p; t.wv = w; t.ra = a; t.rv = v;
        t.rd_a = rda; t.chk_rd = chk; t.exp_rd = erd; t.exp_ret = eret;
        t.exp_cyc = ecyc; t.exp_halt = eh; t.exp_hpc = ehpc; t.exp_to = eto;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver: inputs change on the falling edge
    task automatic drive(input logic r, input logic c, input logic [15:0] p,
                         input logic w, input logic [2:0] a, input logic [15:0] v);
        @(negedge clk);
        rst = r; cv = c; pc = p; wv = w; ra = a; rv = v;
    endtask

    // one full cycle with output sampling 1 time unit after the rising edge
    task automatic cycle(input logic r, input logic c, input logic [15:0] p,
                         input logic w, input logic [2:0] a, input logic [15:0] v);
        drive(r, c, p, w, a, v);
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input int idx, input vec_t t);
        logic [1:0] exp_st;
        drive(t.rst, t.cv, t.pc, t.wv, t.ra, t.rv);
        rd_a = t.rd_a;
        #1;
        if (t.chk_rd) chk($sformatf("v%0d rdata", idx), 32'(d_rdata), 32'(t.exp_rd));
        @(posedge clk);
        #1;
        exp_st = t.exp_halt ? 2'd1 : (t.exp_to ? 2'd2 : 2'd0);
        chk($sformatf("v%0d retired", idx), d_ret, t.exp_ret);
        chk($sformatf("v%0d cycles", idx), d_cyc, t.exp_cyc);
        chk($sformatf("v%0d halt", idx), 32'(d_halt), 32'(t.exp_halt));
        chk($sformatf("v%0d halt_pc", idx), 32'(d_hpc), 32'(t.exp_hpc));
        chk($sformatf("v%0d timeout", idx), 32'(d_to), 32'(t.exp_to));
        chk($sformatf("v%0d done", idx), 32'(d_done), 32'(t.exp_halt | t.exp_to));
        chk($sformatf("v%0d state", idx), 32'(d_st), 32'(exp_st));
    endtask

    initial begin
        rst = 1'b1; cv = 1'b0; pc = '0; wv = 1'b0; ra = '0; rv = '0; rd_a = '0;

        // reset held 3 cycles with a commit present; the first read is of an unknown state
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1, 1, 16'h5, 1, 3'd2, 16'hAAAA, 3'd2, k != 0, 16'h0, 0, 0, 0, 16'h0, 0));
        // all shadow registers read 0 after reset
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 0, 16'h0, 0, 3'd0, 16'h0, 3'(i), 1, 16'h0, 0, 32'(i + 1), 0, 16'h0, 0));
        // writes; a same-cycle read returns the old value
        vecs.push_back(mk(0, 1, 16'h10, 1, 3'd3, 16'hBEEF, 3'd3, 1, 16'h0,    1,  9, 0, 16'h0, 0));
        vecs.push_back(mk(0, 1, 16'h11, 1, 3'd3, 16'h1234, 3'd3, 1, 16'hBEEF, 2, 10, 0, 16'h0, 0));
        vecs.push_back(mk(0, 1, 16'h12, 0, 3'd3, 16'hFFFF, 3'd3, 1, 16'h1234, 3, 11, 0, 16'h0, 0));
        vecs.push_back(mk(0, 0, 16'h0,  0, 3'd0, 16'h0,    3'd3, 1, 16'h1234, 3, 12, 0, 16'h0, 0));
        // broken repeat
        vecs.push_back(mk(0, 1, 16'h30, 0, 3'd0, 16'h0, 3'd3, 1, 16'h1234, 4, 13, 0, 16'h0, 0));
        vecs.push_back(mk(0, 1, 16'h31, 0, 3'd0, 16'h0, 3'd3, 1, 16'h1234, 5, 14, 0, 16'h0, 0));
        vecs.push_back(mk(0, 1, 16'h30, 0, 3'd0, 16'h0, 3'd3, 1, 16'h1234, 6, 15, 0, 16'h0, 0));
        vecs.push_back(mk(0, 1, 16'h31, 0, 3'd0, 16'h0, 3'd3, 1, 16'h1234, 7, 16, 0, 16'h0, 0));
        // register 0 is writable
        vecs.push_back(mk(0, 1, 16'h40, 1, 3'd0, 16'h5A5A, 3'd0, 1, 16'h0,    8, 17, 0, 16'h0, 0));
        vecs.push_back(mk(0, 1, 16'h20, 0, 3'd0, 16'h0,    3'd0, 1, 16'h5A5A, 9, 18, 0, 16'h0, 0));
        // idle gaps do not break a repeat run
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 0, 16'h0, 0, 3'd0, 16'h0, 3'd0, 1, 16'h5A5A, 9, 32'(19 + i), 0, 16'h0, 0));
        // halting commit still writes and counts
        vecs.push_back(mk(0, 1, 16'h20, 1, 3'd1, 16'h7777, 3'd1, 1, 16'h0,    10, 24, 1, 16'h20, 0));
        // commits after halt are ignored
        vecs.push_back(mk(0, 1, 16'h21, 1, 3'd1, 16'h1111, 3'd1, 1, 16'h7777, 10, 24, 1, 16'h20, 0));
        vecs.push_back(mk(0, 0, 16'h0,  0, 3'd0, 16'h0,    3'd1, 1, 16'h7777, 10, 24, 1, 16'h20, 0));
        vecs.push_back(mk(0, 1, 16'h20, 1, 3'd1, 16'h2222, 3'd1, 1, 16'h7777, 10, 24, 1, 16'h20, 0));
        // reset leaves HALTED and clears everything
        vecs.push_back(mk(1, 1, 16'h99, 1, 3'd1, 16'h3333, 3'd1, 1, 16'h7777, 0, 0, 0, 16'h0, 0));
        vecs.push_back(mk(0, 0, 16'h0,  0, 3'd0, 16'h0,    3'd1, 1, 16'h0,    0, 1, 0, 16'h0, 0));

        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

        // timeout on u_sat (TIMEOUT_P=8): one commit, then idle cycles
        cycle(1, 0, 16'h0, 0, 3'd0, 16'h0);
        cycle(0, 1, 16'h50, 0, 3'd0, 16'h0);
        chk("to commit cycles", 32'(s_cyc), 32'd1);
        for (int i = 0; i < 7; i++) cycle(0, 0, 16'h0, 0, 3'd0, 16'h0);
        chk("to 7 idle timeout", 32'(s_to), 32'd0);
        chk("to 7 idle cycles", 32'(s_cyc), 32'd8);
        cycle(0, 0, 16'h0, 0, 3'd0, 16'h0);
        chk("to 8 idle timeout", 32'(s_to), 32'd1);
        chk("to 8 idle done", 32'(s_done), 32'd1);
        chk("to 8 idle halt", 32'(s_halt), 32'd0);
        chk("to 8 idle cycles", 32'(s_cyc), 32'd9);
        chk("to state", 32'(s_st), 32'd2);
        chk("to wide dut still run", 32'(d_to), 32'd0);
        cycle(0, 1, 16'h60, 1, 3'd2, 16'hABCD);
        chk("to hold cycles", 32'(s_cyc), 32'd9);
        chk("to hold retired", 32'(s_ret), 32'd1);
        chk("to hold timeout", 32'(s_to), 32'd1);

        // saturation on u_sat (4-bit counters): 20 distinct-PC commits
        cycle(1, 0, 16'h0, 0, 3'd0, 16'h0);
        for (int i = 0; i < 20; i++) begin
            cycle(0, 1, 16'(16'h100 + i), 0, 3'd0, 16'h0);
            chk($sformatf("sat retired %0d", i), 32'(s_ret), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
        end
        chk("sat cycles", 32'(s_cyc), 32'd15);
        chk("sat halt", 32'(s_halt), 32'd0);
        chk("wide retired 20", d_ret, 32'd20);
        cycle(1, 1, 16'h200, 0, 3'd0, 16'h0);
        chk("sat reset retired", 32'(s_ret), 32'd0);
        chk("sat reset cycles", 32'(s_cyc), 32'd0);
        chk("wide reset retired", d_ret, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
